// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage load/store responder (internal RAM or external bus)
//
// Optional feature macro: MEM_TIMEOUT_EN (timeout counter and sticky bus_err).
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   re, we, sel         load / store request and target (0 = internal RAM, 1 = external bus)
//   addr, wdata, alu_in EX/MEM address, store data and ALU result
//   stall               holds the front of the pipeline while an access is outstanding
//   wb_data             write-back word for MEM/WB
//   ext_req, ext_we     external request (held until ack) and direction
//   ext_addr, ext_wdata external address and write data
//   ext_ack, ext_rdata  external completion and read data
//   bus_err, err_clr    sticky timeout flag and its synchronous clear

module mem_stage_ctrl #(
  parameter int RAM_AW  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic        sel,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] alu_in,
  output logic        stall,
  output logic [15:0] wb_data,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [15:0] ext_wdata,
  input  logic        ext_ack,
  input  logic [15:0] ext_rdata,
  output logic        bus_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_DONE  = 2'd1,
    EXT      = 2'd2,
    EXT_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  // A store takes priority over a load when both are requested.
  logic int_store;
  logic int_load;
  logic ext_access;

  assign int_store  = we & ~sel;
  assign int_load   = re & ~we & ~sel;
  assign ext_access = (re | we) & sel;

  logic [15:0]       mem [0:(1 << RAM_AW) - 1];
  logic [15:0]       ram_q;
  logic [15:0]       rdata_q;
  logic [RAM_AW-1:0] ram_idx;
  logic              tmo_hit;

  assign ram_idx = addr[RAM_AW-1:0];

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt;
  logic          bus_err_q;

  // The counter holds at TIMEOUT, so EXT lasts TIMEOUT+1 cycles when no ack arrives.
  assign tmo_hit = (state == EXT) && !ext_ack && (tmo_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state != EXT) begin
      tmo_cnt <= '0;
    end else if (!ext_ack && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else if (tmo_hit) begin
      bus_err_q <= 1'b1;
    end else if (err_clr) begin
      bus_err_q <= 1'b0;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_err_clr;

  assign tmo_hit        = 1'b0;
  assign bus_err        = 1'b0;
  assign unused_err_clr = err_clr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    wb_data  = alu_in;
    case (state)
      IDLE: begin
        if (int_load) begin
          stall    = 1'b1;
          state_nx = RD_DONE;
        end else if (ext_access) begin
          stall    = 1'b1;
          state_nx = EXT;
        end
      end
      RD_DONE: begin
        wb_data  = ram_q;
        state_nx = IDLE;
      end
      EXT: begin
        stall = 1'b1;
        if (ext_ack || tmo_hit) begin
          state_nx = EXT_DONE;
        end
      end
      EXT_DONE: begin
        // ext_we still describes the access just completed.
        wb_data  = ext_we ? alu_in : rdata_q;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // External bus registers; ext_req drops asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= 16'h0000;
      ext_wdata <= 16'h0000;
      rdata_q   <= 16'h0000;
    end else if (state == IDLE && ext_access) begin
      ext_req   <= 1'b1;
      ext_we    <= we;
      ext_addr  <= addr;
      ext_wdata <= wdata;
    end else if (state == EXT) begin
      if (ext_ack) begin
        rdata_q <= ext_rdata;
        ext_req <= 1'b0;
      end else if (tmo_hit) begin
        rdata_q <= 16'hFFFF;
        ext_req <= 1'b0;
      end
    end
  end

  // Data RAM is not reset; the read register feeds wb_data in RD_DONE.
  always_ff @(posedge clk) begin
    if (state == IDLE && int_store) begin
      mem[ram_idx] <= wdata;
    end
    if (state == IDLE && int_load) begin
      ram_q <= mem[ram_idx];
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl

module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        re;
  logic        we;
  logic        sel;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] alu_in;
  logic        stall;
  logic [15:0] wb_data;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [15:0] ext_wdata;
  logic        ext_ack;
  logic [15:0] ext_rdata;
  logic        bus_err;
  logic        err_clr;

  int n_chk;
  int n_fail;

  mem_stage_ctrl #(.RAM_AW(10), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .re        (re),
    .we        (we),
    .sel       (sel),
    .addr      (addr),
    .wdata     (wdata),
    .alu_in    (alu_in),
    .stall     (stall),
    .wb_data   (wb_data),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata),
    .bus_err   (bus_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    re        = 1'b0;
    we        = 1'b0;
    sel       = 1'b0;
    addr      = 16'h0000;
    wdata     = 16'h0000;
    ext_ack   = 1'b0;
    ext_rdata = 16'h0000;
    err_clr   = 1'b0;
  endtask

  // Runs one external access from IDLE; called and returns at posedge+1.
  // ack_at = EXT cycle index carrying ext_ack (0 = never). Bounded to 40 cycles.
  task automatic run_ext(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input int ack_at, input logic [15:0] rd,
                         output int nstall, output logic [15:0] wb, output logic req_after,
                         output logic s_we, output logic [15:0] s_addr, output logic [15:0] s_wdata);
    int  ext_cyc;
    bit  done;
    re  = ~w;
    we  = w;
    sel = 1'b1;
    addr  = a;
    wdata = d;
    nstall    = 0;
    ext_cyc   = 0;
    done      = 1'b0;
    wb        = 16'hxxxx;
    req_after = 1'bx;
    s_we      = 1'bx;
    s_addr    = 16'hxxxx;
    s_wdata   = 16'hxxxx;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ext_req === 1'b1) begin
        ext_cyc = ext_cyc + 1;
        s_we    = ext_we;
        s_addr  = ext_addr;
        s_wdata = ext_wdata;
      end
      ext_ack   = (ack_at != 0) && (ext_cyc == ack_at);
      ext_rdata = ext_ack ? rd : 16'h0000;
      @(negedge clk);
      if (stall === 1'b1) begin
        nstall = nstall + 1;
      end else begin
        done      = 1'b1;
        wb        = wb_data;
        req_after = ext_req;
      end
      @(posedge clk); #1;
    end
    re      = 1'b0;
    we      = 1'b0;
    ext_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    alu_in = 16'h0BAD;
    rst    = 1'b1;
    #2;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_chk++; if (wb_data !== 16'h0BAD) begin n_fail++; $display("FAIL reset_wb_data: got %h want 0bad", wb_data); end
    n_chk++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL reset_ext_req: got %b want 0", ext_req); end
    n_chk++; if (ext_we !== 1'b0) begin n_fail++; $display("FAIL reset_ext_we: got %b want 0", ext_we); end
    n_chk++; if (ext_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_ext_addr: got %h want 0000", ext_addr); end
    n_chk++; if (ext_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_ext_wdata: got %h want 0000", ext_wdata); end
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ram();
    // store 0012 <- BEEF: no stall
    we = 1'b1; sel = 1'b0; addr = 16'h0012; wdata = 16'hBEEF;
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ram_store_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    // load 0012: one stall cycle, then data in RD_DONE
    we = 1'b0; re = 1'b1; wdata = 16'h0000; alu_in = 16'h1111;
    @(negedge clk);
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ram_load_stall: got %b want 1", stall); end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ram_rd_done_stall: got %b want 0", stall); end
    n_chk++; if (wb_data !== 16'hBEEF) begin n_fail++; $display("FAIL ram_rd_done_data: got %h want beef", wb_data); end
    @(posedge clk); #1;
    // we+re both set: store wins; address 0412 aliases to 0012 with RAM_AW=10
    we = 1'b1; re = 1'b1; addr = 16'h0412; wdata = 16'hCAFE;
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ram_we_wins_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    we = 1'b0; re = 1'b1; addr = 16'h0012; wdata = 16'h0000;
    @(negedge clk);
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ram_load2_stall: got %b want 1", stall); end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (wb_data !== 16'hCAFE) begin n_fail++; $display("FAIL ram_alias_data: got %h want cafe", wb_data); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_no_op();
    idle_inputs();
    alu_in = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL noop_stall[%0d]: got %b want 0", i, stall); end
      n_chk++; if (wb_data !== 16'h1234) begin n_fail++; $display("FAIL noop_wb_data[%0d]: got %h want 1234", i, wb_data); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ext_read();
    int          ns;
    logic [15:0] wb;
    logic        rq;
    logic        swe;
    logic [15:0] sa;
    logic [15:0] sd;
    alu_in = 16'h7777;
    run_ext(1'b0, 16'hF000, 16'h0000, 3, 16'h00A5, ns, wb, rq, swe, sa, sd);
    n_chk++; if (ns != 4) begin n_fail++; $display("FAIL ext_rd_stall_cycles: got %0d want 4", ns); end
    n_chk++; if (swe !== 1'b0) begin n_fail++; $display("FAIL ext_rd_we: got %b want 0", swe); end
    n_chk++; if (sa !== 16'hF000) begin n_fail++; $display("FAIL ext_rd_addr: got %h want f000", sa); end
    n_chk++; if (wb !== 16'h00A5) begin n_fail++; $display("FAIL ext_rd_wb_data: got %h want 00a5", wb); end
    n_chk++; if (rq !== 1'b0) begin n_fail++; $display("FAIL ext_rd_req_drop: got %b want 0", rq); end
  endtask

  task automatic test_ext_write();
    int          ns;
    logic [15:0] wb;
    logic        rq;
    logic        swe;
    logic [15:0] sa;
    logic [15:0] sd;
    alu_in = 16'h3C3C;
    run_ext(1'b1, 16'h8004, 16'h5A5A, 1, 16'hDEAD, ns, wb, rq, swe, sa, sd);
    n_chk++; if (ns != 2) begin n_fail++; $display("FAIL ext_wr_stall_cycles: got %0d want 2", ns); end
    n_chk++; if (swe !== 1'b1) begin n_fail++; $display("FAIL ext_wr_we: got %b want 1", swe); end
    n_chk++; if (sd !== 16'h5A5A) begin n_fail++; $display("FAIL ext_wr_wdata: got %h want 5a5a", sd); end
    n_chk++; if (sa !== 16'h8004) begin n_fail++; $display("FAIL ext_wr_addr: got %h want 8004", sa); end
    n_chk++; if (wb !== 16'h3C3C) begin n_fail++; $display("FAIL ext_wr_wb_data: got %h want 3c3c", wb); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int          ns;
    logic [15:0] wb;
    logic        rq;
    logic        swe;
    logic [15:0] sa;
    logic [15:0] sd;
    alu_in = 16'h4444;
    run_ext(1'b0, 16'hF100, 16'h0000, 0, 16'h0000, ns, wb, rq, swe, sa, sd);
    n_chk++; if (ns != 6) begin n_fail++; $display("FAIL tmo_stall_cycles: got %0d want 6", ns); end
    n_chk++; if (wb !== 16'hFFFF) begin n_fail++; $display("FAIL tmo_wb_data: got %h want ffff", wb); end
    @(negedge clk);
    n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL tmo_bus_err_set: got %b want 1", bus_err); end
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL tmo_bus_err_clr: got %b want 0", bus_err); end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_timeout();
    int          ns;
    logic [15:0] wb;
    logic        rq;
    logic        swe;
    logic [15:0] sa;
    logic [15:0] sd;
    alu_in = 16'h4444;
    run_ext(1'b0, 16'hF100, 16'h0000, 12, 16'h0C0C, ns, wb, rq, swe, sa, sd);
    n_chk++; if (ns != 13) begin n_fail++; $display("FAIL long_wait_stall_cycles: got %0d want 13", ns); end
    n_chk++; if (wb !== 16'h0C0C) begin n_fail++; $display("FAIL long_wait_wb_data: got %h want 0c0c", wb); end
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL long_wait_bus_err: got %b want 0", bus_err); end
  endtask
`endif

  task automatic test_reset_mid_access();
    alu_in = 16'h2468;
    re = 1'b1; sel = 1'b1; addr = 16'hF000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++; if (ext_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_before: got %b want 1", ext_req); end
    #1;
    rst = 1'b1;
    re  = 1'b0;
    we  = 1'b0;
    #1;
    n_chk++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_drop: got %b want 0", ext_req); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", stall); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    ext_ack   = 1'b1;
    ext_rdata = 16'h1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_ack_req[%0d]: got %b want 0", i, ext_req); end
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_ack_stall[%0d]: got %b want 0", i, stall); end
      n_chk++; if (wb_data !== 16'h2468) begin n_fail++; $display("FAIL rstmid_late_ack_wb[%0d]: got %h want 2468", i, wb_data); end
      n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_bus_err[%0d]: got %b want 0", i, bus_err); end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_ram();
    test_no_op();
    test_ext_read();
    test_ext_write();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
